// File: rtl/reg_bank_pkg.sv
// Shared register-file constants. The destination mux and the control unit
// import the same names, so register numbers are defined in one place only.
package reg_bank_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_RA   = 5'd31;

  localparam int unsigned SP_INIT_DEFAULT = 227;

endpackage

// File: rtl/reg_bank.sv
// 32-entry general-purpose register file: two combinational read ports, one
// synchronous write port, and a registered write-commit pulse.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int          DATA_W  = 32,
  parameter int unsigned SP_INIT = SP_INIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  reg_addr_t         ReadReg1,
  input  reg_addr_t         ReadReg2,
  input  reg_addr_t         WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              WriteDone
);

  localparam logic [DATA_W-1:0] SP_VAL = DATA_W'(SP_INIT);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              done_q;
  logic              done_d;
  logic              wr_en;

  // RegWrite gates first so an undefined WriteReg cannot leak into the enable.
  assign wr_en  = RegWrite && (WriteReg != REG_ZERO);
  assign done_d = wr_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (reg_addr_t'(i) == REG_SP) ? SP_VAL : '0;
      end
      done_q <= 1'b0;
    end else begin
      if (wr_en) begin
        regs_q[WriteReg] <= WriteData;
      end
      done_q <= done_d;
    end
  end

  // No write bypass: reads always return the pre-edge contents.
  assign ReadData1 = (ReadReg1 == REG_ZERO) ? '0 : regs_q[ReadReg1];
  assign ReadData2 = (ReadReg2 == REG_ZERO) ? '0 : regs_q[ReadReg2];
  assign WriteDone = done_q;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: stimulus queues expected port values for each
// cycle, a negedge monitor pops and compares them against the outputs.
module tb_reg_bank;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              RegWrite;
  logic [4:0]        ReadReg1;
  logic [4:0]        ReadReg2;
  logic [4:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic              WriteDone;

  reg_bank #(.DATA_W(DATA_W), .SP_INIT(227)) dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .WriteDone (WriteDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] e1;
    logic [DATA_W-1:0] e2;
    logic              ewd;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_vec = 0;
  int   n_err = 0;
  logic [DATA_W-1:0] mdl [32];

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      n_vec++;
      if (ReadData1 !== cur.e1 || ReadData2 !== cur.e2 || WriteDone !== cur.ewd) begin
        n_err++;
        $display("FAIL %s: got rd1=%h rd2=%h wd=%b, expected rd1=%h rd2=%h wd=%b",
                 cur.tag, ReadData1, ReadData2, WriteDone, cur.e1, cur.e2, cur.ewd);
      end
    end
  end

  task automatic expect_now(input string tag, input logic [DATA_W-1:0] e1,
                            input logic [DATA_W-1:0] e2, input logic ewd);
    exp_t e;
    e.tag = tag;
    e.e1  = e1;
    e.e2  = e2;
    e.ewd = ewd;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      ReadReg1 = 5'(2 * i);
      ReadReg2 = 5'(2 * i + 1);
      expect_now(tag, mdl[2 * i], mdl[2 * i + 1], 1'b0);
      cyc();
    end
  endtask

  initial begin
    reset     = 1'b0;
    RegWrite  = 1'b0;
    ReadReg1  = '0;
    ReadReg2  = '0;
    WriteReg  = '0;
    WriteData = '0;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdl[29] = 32'd227;

    // Reset for one cycle, then sweep all addresses.
    cyc();
    reset = 1'b1;
    read_all("reset_sweep");

    // Write 0xDEADBEEF to r8: old value before edge, new after, one-cycle done.
    ReadReg1 = 5'd8; ReadReg2 = 5'd29;
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'hDEADBEEF;
    expect_now("wr8_pre", 32'h0, 32'd227, 1'b0);
    cyc();
    RegWrite = 1'b0;
    expect_now("wr8_post", 32'hDEADBEEF, 32'd227, 1'b1);
    cyc();
    expect_now("wr8_done_drop", 32'hDEADBEEF, 32'd227, 1'b0);
    cyc();
    mdl[8] = 32'hDEADBEEF;

    // Write to r0 is discarded.
    ReadReg1 = 5'd0; ReadReg2 = 5'd8;
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h12345678;
    expect_now("wr0_pre", 32'h0, 32'hDEADBEEF, 1'b0);
    cyc();
    RegWrite = 1'b0;
    expect_now("wr0_post", 32'h0, 32'hDEADBEEF, 1'b0);
    cyc();
    expect_now("wr0_settle", 32'h0, 32'hDEADBEEF, 1'b0);
    cyc();

    // Back-to-back 5 then 7 into r31, both ports on r31.
    ReadReg1 = 5'd31; ReadReg2 = 5'd31;
    RegWrite = 1'b1; WriteReg = 5'd31; WriteData = 32'd5;
    expect_now("b2b_pre", 32'h0, 32'h0, 1'b0);
    cyc();
    WriteData = 32'd7;
    expect_now("b2b_first", 32'd5, 32'd5, 1'b1);
    cyc();
    RegWrite = 1'b0;
    expect_now("b2b_second", 32'd7, 32'd7, 1'b1);
    cyc();
    expect_now("b2b_done_drop", 32'd7, 32'd7, 1'b0);
    cyc();

    // Reset wins over a coincident write to r29.
    ReadReg1 = 5'd29; ReadReg2 = 5'd31;
    reset = 1'b0; RegWrite = 1'b1; WriteReg = 5'd29; WriteData = 32'hFF;
    expect_now("rst_wr_pre", 32'd227, 32'd7, 1'b0);
    cyc();
    reset = 1'b1; RegWrite = 1'b0;
    expect_now("rst_wr_post", 32'd227, 32'h0, 1'b0);
    cyc();
    mdl[8] = '0;

    // Reset between two writes discards the first; the next write commits.
    ReadReg1 = 5'd5; ReadReg2 = 5'd8;
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h11;
    expect_now("rbw_pre", 32'h0, 32'h0, 1'b0);
    cyc();
    reset = 1'b0; RegWrite = 1'b0;
    expect_now("rbw_first", 32'h11, 32'h0, 1'b1);
    cyc();
    reset = 1'b1; RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'h22;
    expect_now("rbw_cleared", 32'h0, 32'h0, 1'b0);
    cyc();
    RegWrite = 1'b0;
    expect_now("rbw_second", 32'h22, 32'h0, 1'b1);
    cyc();
    mdl[5] = 32'h22;

    // RegWrite low with undefined address: nothing changes for 10 cycles.
    ReadReg1 = 5'd5; ReadReg2 = 5'd29;
    WriteReg = 'x; WriteData = 32'hAAAA_AAAA;
    for (int i = 0; i < 10; i++) begin
      expect_now("idle_hold", 32'h22, 32'd227, 1'b0);
      cyc();
    end
    read_all("idle_sweep");

    for (int i = 0; i < 5 && sb.size() != 0; i++) cyc();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

endmodule
